// File: rtl/icache_fetch_responder_pkg.sv
// Shared constants and FSM state codes for the instruction-cache fetch responder.
package icache_fetch_responder_pkg;

    localparam int ICACHE_IDX_BITS = 7;
    localparam int INST_ADDR_W     = 32;
    localparam int INST_W          = 32;

    localparam logic [INST_W-1:0] DATA_FREE = '0;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_FILL = 2'd1,
        IC_RESP = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_fetch_responder_tag_array.sv
// Direct-mapped valid/tag/data store: two combinational read ports, one write port,
// and a synchronous clear of every valid bit on rst.
import icache_fetch_responder_pkg::*;

module icache_tag_array #(
    parameter int INDEX_BITS = ICACHE_IDX_BITS,
    parameter int TAG_W      = INST_ADDR_W - ICACHE_IDX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] idx_o,
    output logic                  valid_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [INST_W-1:0]     data_o,
    input  logic [INDEX_BITS-1:0] idx_t,
    output logic                  valid_t,
    output logic [TAG_W-1:0]      tag_t,
    output logic [INST_W-1:0]     data_t,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [TAG_W-1:0]      wtag,
    input  logic [INST_W-1:0]     wdata
);
    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [INST_W-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign valid_o = valid[idx_o];
    assign tag_o   = tag_mem[idx_o];
    assign data_o  = data_mem[idx_o];
    assign valid_t = valid[idx_t];
    assign tag_t   = tag_mem[idx_t];
    assign data_t  = data_mem[idx_t];

endmodule

// File: rtl/icache_fetch_responder.sv
// Instruction-cache responder: direct-mapped lookup for both fetch slots and a
// byte-serial single-word fill for O-slot misses.
import icache_fetch_responder_pkg::*;

module icache_fetch_responder #(
    parameter int INDEX_BITS = ICACHE_IDX_BITS,
    parameter int ADDR_W     = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              instEn,
    input  logic [ADDR_W-1:0] instAddrO,
    input  logic [ADDR_W-1:0] instAddrT,
    input  logic              flush,
    output logic              hitO,
    output logic [INST_W-1:0] cacheInstO,
    output logic              hitT,
    output logic [INST_W-1:0] cacheInstT,
    output logic              memInstOutEn,
    output logic [INST_W-1:0] memInst,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memGnt,
    input  logic [7:0]        memData,
    output logic [1:0]        dbg_state
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    ic_state_e         state;
    logic [ADDR_W-1:0] base;
    logic [2:0]        req_cnt;
    logic [1:0]        rcv_cnt;
    logic              pend;
    logic [7:0]        b0, b1, b2;
    logic [INST_W-1:0] mem_inst_q;

    logic                  rd_valid_o, rd_valid_t;
    logic [TAG_W-1:0]      rd_tag_o, rd_tag_t;
    logic [INST_W-1:0]     rd_data_o, rd_data_t;
    logic                  fill_done;
    logic                  unused_addr_bits;

    icache_tag_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .idx_o   (instAddrO[INDEX_BITS+1:2]),
        .valid_o (rd_valid_o),
        .tag_o   (rd_tag_o),
        .data_o  (rd_data_o),
        .idx_t   (instAddrT[INDEX_BITS+1:2]),
        .valid_t (rd_valid_t),
        .tag_t   (rd_tag_t),
        .data_t  (rd_data_t),
        .we      (fill_done),
        .widx    (base[INDEX_BITS+1:2]),
        .wtag    (base[ADDR_W-1:INDEX_BITS+2]),
        .wdata   ({memData, b2, b1, b0})
    );

    assign unused_addr_bits = &{1'b0, instAddrO[1:0], instAddrT[1:0], base[1:0]};

    assign hitO       = instEn & rd_valid_o & (rd_tag_o == instAddrO[ADDR_W-1:INDEX_BITS+2]);
    assign hitT       = instEn & rd_valid_t & (rd_tag_t == instAddrT[ADDR_W-1:INDEX_BITS+2]);
    assign cacheInstO = hitO ? rd_data_o : DATA_FREE;
    assign cacheInstT = hitT ? rd_data_t : DATA_FREE;

    // Arbiter handshake: memReq/memAddr are offered combinationally; a request is
    // transferred on a cycle with memReq & memGnt, and its byte appears on memData
    // in the following cycle. memAddr stays on the same byte until it is granted.
    assign memReq       = rdy & (state == IC_FILL) & ~req_cnt[2];
    assign memAddr      = memReq ? base + ADDR_W'(req_cnt) : '0;
    assign memInstOutEn = rdy & ~flush & (state == IC_RESP);
    assign memInst      = mem_inst_q;
    assign dbg_state    = state;

    // The fourth byte is written straight from memData so the line hits in RESP.
    assign fill_done = rdy & ~rst & ~flush & (state == IC_FILL) & pend & (rcv_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IC_IDLE;
            base       <= '0;
            req_cnt    <= '0;
            rcv_cnt    <= '0;
            pend       <= 1'b0;
            b0         <= '0;
            b1         <= '0;
            b2         <= '0;
            mem_inst_q <= '0;
        end else if (rdy) begin
            case (state)
                IC_IDLE: begin
                    if (instEn && !hitO && !flush) begin
                        base    <= instAddrO;
                        req_cnt <= '0;
                        rcv_cnt <= '0;
                        pend    <= 1'b0;
                        state   <= IC_FILL;
                    end
                end
                IC_FILL: begin
                    if (flush) begin
                        pend  <= 1'b0;
                        state <= IC_IDLE;
                    end else begin
                        if (memReq && memGnt) req_cnt <= req_cnt + 3'd1;
                        pend <= memReq & memGnt;
                        if (pend) begin
                            case (rcv_cnt)
                                2'd0: b0 <= memData;
                                2'd1: b1 <= memData;
                                2'd2: b2 <= memData;
                                default: begin
                                    mem_inst_q <= {memData, b2, b1, b0};
                                    state      <= IC_RESP;
                                end
                            endcase
                            rcv_cnt <= rcv_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Self-checking bench for icache_fetch_responder: cycle model of the cache contents and
// fill timeline, plus directed literal checks for each scenario.
`timescale 1ns/1ps
module tb_icache_fetch_responder;
    import icache_fetch_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        instEn = 1'b0;
    logic        flush = 1'b0;
    logic        memGnt = 1'b0;
    logic [31:0] instAddrO = '0;
    logic [31:0] instAddrT = '0;
    logic [7:0]  memData = '0;
    logic        hitO, hitT, memInstOutEn, memReq;
    logic [31:0] cacheInstO, cacheInstT, memInst, memAddr;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    icache_fetch_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy), .instEn(instEn),
        .instAddrO(instAddrO), .instAddrT(instAddrT), .flush(flush),
        .hitO(hitO), .cacheInstO(cacheInstO), .hitT(hitT), .cacheInstT(cacheInstT),
        .memInstOutEn(memInstOutEn), .memInst(memInst), .memReq(memReq),
        .memAddr(memAddr), .memGnt(memGnt), .memData(memData), .dbg_state(dbg_state)
    );

    // ---------------- backing memory ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0010_0513;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    always @(negedge clk) begin : mem_port
        logic        g;
        logic [31:0] a;
        g = memReq && memGnt;
        a = memAddr;
        @(posedge clk);
        #1;
        memData = g ? mem_byte(a) : 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    logic        m_valid [128];
    logic [31:0] m_addr  [128];
    logic [31:0] m_data  [128];
    bit          m_busy, m_resp, m_pend;
    logic [31:0] m_base;
    logic [31:0] m_word = '0;
    int          m_gcnt, m_rcv;

    always @(negedge clk) begin : scoreboard
        logic [6:0]  io, it;
        logic        eho, eht, ereq, eout;
        logic [31:0] eaddr;
        io    = instAddrO[8:2];
        it    = instAddrT[8:2];
        eho   = instEn && m_valid[io] === 1'b1 && m_addr[io] == instAddrO;
        eht   = instEn && m_valid[it] === 1'b1 && m_addr[it] == instAddrT;
        ereq  = rdy && m_busy && m_gcnt < 4;
        eaddr = ereq ? m_base + 32'(m_gcnt) : 32'h0;
        eout  = rdy && !flush && m_resp;
        if (armed) begin
            check("hitO", {31'h0, hitO}, {31'h0, eho});
            check("cacheInstO", cacheInstO, eho ? m_data[io] : 32'h0);
            check("hitT", {31'h0, hitT}, {31'h0, eht});
            check("cacheInstT", cacheInstT, eht ? m_data[it] : 32'h0);
            check("memReq", {31'h0, memReq}, {31'h0, ereq});
            check("memAddr", memAddr, eaddr);
            check("memInstOutEn", {31'h0, memInstOutEn}, {31'h0, eout});
            check("memInst", memInst, m_word);
        end
        if (rst) begin
            for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
            m_busy = 0; m_resp = 0; m_pend = 0; m_gcnt = 0; m_rcv = 0; m_word = '0;
        end else if (rdy) begin
            if (m_resp) begin
                m_resp = 0;
            end else if (m_busy) begin
                if (flush) begin
                    m_busy = 0;
                    m_pend = 0;
                end else begin
                    if (m_pend) begin
                        m_rcv++;
                        if (m_rcv == 4) begin
                            m_valid[m_base[8:2]] = 1'b1;
                            m_addr[m_base[8:2]]  = m_base;
                            m_data[m_base[8:2]]  = mem_word(m_base);
                            m_word = mem_word(m_base);
                            m_busy = 0;
                            m_resp = 1;
                        end
                    end
                    m_pend = ereq && memGnt;
                    if (m_pend) m_gcnt++;
                end
            end else if (instEn && !eho && !flush) begin
                m_busy = 1; m_base = instAddrO; m_gcnt = 0; m_rcv = 0; m_pend = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int max, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!memInstOutEn && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!memInstOutEn) begin
            errors++;
            $display("FAIL %s: no memInstOutEn within %0d cycles", name, max);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cyc();
        armed = 1'b1;
        cyc();
        @(negedge clk);
        check("rst_memReq", {31'h0, memReq}, 32'h0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_memInstOutEn", {31'h0, memInstOutEn}, 32'h0);
        check("rst_memInst", memInst, 32'h0);
        cyc();
        rst = 1'b0;

        // 1: cold miss at 0x100, grant always
        instEn = 1'b1; instAddrO = 32'h100; instAddrT = 32'h104; memGnt = 1'b1;
        @(negedge clk);
        check("t1_cold_hitO", {31'h0, hitO}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk);
            check("t1_memReq", {31'h0, memReq}, 32'h1);
            check("t1_memAddr", memAddr, 32'h100 + 32'(k));
        end
        cyc();
        @(negedge clk);
        check("t1_not_early", {31'h0, memInstOutEn}, 32'h0);
        cyc();
        @(negedge clk);
        check("t1_outen", {31'h0, memInstOutEn}, 32'h1);
        check("t1_memInst", memInst, 32'h0010_0513);

        // 2: hit after fill, T slot unfilled
        cyc();
        @(negedge clk);
        check("t2_hitO", {31'h0, hitO}, 32'h1);
        check("t2_cacheInstO", cacheInstO, 32'h0010_0513);
        check("t2_hitT", {31'h0, hitT}, 32'h0);
        check("t2_memReq", {31'h0, memReq}, 32'h0);

        // 3: conflicting tag on the same index
        cyc();
        instAddrO = 32'h300;
        @(negedge clk);
        check("t3_conflict_hitO", {31'h0, hitO}, 32'h0);
        wait_resp(20, "t3_resp");
        check("t3_memInst", memInst, 32'hC0DE_0300);
        cyc();
        instAddrO = 32'h100; flush = 1'b1;
        @(negedge clk);
        check("t3_evicted_hitO", {31'h0, hitO}, 32'h0);
        check("t3_flush_blocks", {31'h0, memReq}, 32'h0);

        // 5: flush after two bytes, then an immediate new miss at 0x200
        cyc();
        flush = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        flush = 1'b1;
        @(negedge clk);
        check("t5_flush_noresp", {31'h0, memInstOutEn}, 32'h0);
        cyc();
        flush = 1'b0; instAddrO = 32'h200; instAddrT = 32'h100;
        @(negedge clk);
        check("t5_still_miss", {31'h0, hitT}, 32'h0);

        // 4: the 0x200 fill stalls three cycles on byte 2
        cyc();
        @(negedge clk);
        check("t5_new_addr", memAddr, 32'h200);
        cyc();
        cyc();
        memGnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall_req", {31'h0, memReq}, 32'h1);
            check("t4_stall_addr", memAddr, 32'h202);
            cyc();
        end
        memGnt = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        check("t4_late_not_yet", {31'h0, memInstOutEn}, 32'h0);
        cyc();
        @(negedge clk);
        check("t4_late_outen", {31'h0, memInstOutEn}, 32'h1);
        check("t4_memInst", memInst, 32'hC0DE_0200);

        // 6: rdy low for two cycles mid-fill
        cyc();
        instAddrO = 32'h400;
        cyc(); cyc(); cyc();
        memGnt = 1'b0;
        cyc();
        rdy = 1'b0;
        @(negedge clk);
        check("t6_rdy0_req", {31'h0, memReq}, 32'h0);
        cyc();
        @(negedge clk);
        check("t6_rdy0_req2", {31'h0, memReq}, 32'h0);
        cyc();
        rdy = 1'b1; memGnt = 1'b1;
        @(negedge clk);
        check("t6_resume_addr", memAddr, 32'h402);
        wait_resp(20, "t6_resp");
        check("t6_memInst", memInst, 32'hC0DE_0400);

        // reset in the middle of a fill
        cyc();
        instAddrO = 32'h500;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; instEn = 1'b0;
        @(negedge clk);
        check("rr_hitO", {31'h0, hitO}, 32'h0);
        check("rr_cacheInstO", cacheInstO, 32'h0);
        check("rr_memReq", {31'h0, memReq}, 32'h0);
        check("rr_memAddr", memAddr, 32'h0);
        check("rr_memInstOutEn", {31'h0, memInstOutEn}, 32'h0);
        check("rr_memInst", memInst, 32'h0);
        cyc();
        instEn = 1'b1; flush = 1'b1; instAddrO = 32'h300; instAddrT = 32'h400;
        @(negedge clk);
        check("rr_valid_O", {31'h0, hitO}, 32'h0);
        check("rr_valid_T", {31'h0, hitT}, 32'h0);
        cyc();
        instEn = 1'b0; flush = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
